// File: rtl/me_pkg.sv
// me_pkg: shared defaults, row-address width and loader state encoding for the ME window loader
package me_pkg;
    localparam int MACRO_DIM_DEF  = 16;
    localparam int SEARCH_DIM_DEF = 48;
    localparam int PIXEL_W_DEF    = 8;
    localparam int ROW_AW         = 6;
    typedef enum logic [2:0] {
        IDLE,
        LOAD_CUR,
        LOAD_SW,
        KICK,
        WAIT_BUSY,
        WAIT_DONE
    } ld_state_e;
endpackage

// File: rtl/me_row_packer.sv
// me_row_packer: shifts pixels into a row word (first pixel ends in the MSBs) and flags each row's last column
module me_row_packer #(
    parameter int MAX_LEN = 48,
    parameter int PIXEL_W = 8,
    parameter int CNT_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [PIXEL_W-1:0]         pixel_i,
    input  logic [CNT_W-1:0]           len_i,
    output logic [MAX_LEN*PIXEL_W-1:0] row_o,
    output logic                       row_done_o
);
    localparam int W = MAX_LEN*PIXEL_W;
    logic [W-1:0]     pack_q, pack_d;
    logic [CNT_W-1:0] col_q, col_d;
    // shift in on each push; the column wraps at len_i-1 so it never runs past the row
    always_comb begin
        pack_d     = push_i ? {pack_q[W-PIXEL_W-1:0], pixel_i} : pack_q;
        row_done_o = push_i && (col_q == len_i - 1'b1);
        col_d      = row_done_o ? '0 : push_i ? col_q + 1'b1 : col_q;
    end
    // pack register and column counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q <= '0;
            col_q  <= '0;
        end else begin
            pack_q <= pack_d;
            col_q  <= col_d;
        end
    end
    assign row_o = pack_d;
endmodule

// File: rtl/me_window_loader.sv
// me_window_loader: packs a raster pixel stream into current-macroblock and search-window RAM rows,
// then kicks the motion-estimation controller and waits for it to finish.
// Build option ME_LOAD_CHECK_EN adds in_last framing check with a sticky err flag.
module me_window_loader
    import me_pkg::*;
#(
    parameter int MACRO_DIM  = MACRO_DIM_DEF,
    parameter int SEARCH_DIM = SEARCH_DIM_DEF,
    parameter int PIXEL_W    = PIXEL_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [PIXEL_W-1:0]            in_pixel,
    input  logic                          in_valid,
    output logic                          in_ready,
`ifdef ME_LOAD_CHECK_EN
    input  logic                          in_last,
    output logic                          err,
`endif
    output logic                          cur_we,
    output logic [ROW_AW-1:0]             cur_waddr,
    output logic [MACRO_DIM*PIXEL_W-1:0]  cur_wdata,
    output logic                          sw_we,
    output logic [ROW_AW-1:0]             sw_waddr,
    output logic [SEARCH_DIM*PIXEL_W-1:0] sw_wdata,
    output logic                          me_start,
    input  logic                          me_ready,
    output logic                          block_done,
    output logic                          busy
);
    localparam int CW = MACRO_DIM*PIXEL_W;
    localparam int SW = SEARCH_DIM*PIXEL_W;
    ld_state_e         state_q, state_d;
    logic [ROW_AW-1:0] row_q, row_d, len;
    logic [SW-1:0]     row_word;
    logic              xfer, row_done, last_row, region_done;
    logic              cur_we_q, cur_we_d, sw_we_q, sw_we_d;
    logic [ROW_AW-1:0] cur_waddr_q, cur_waddr_d, sw_waddr_q, sw_waddr_d;
    logic [CW-1:0]     cur_wdata_q, cur_wdata_d;
    logic [SW-1:0]     sw_wdata_q, sw_wdata_d;
    // handshake qualification and the row length of the region being loaded
    always_comb begin
        xfer = in_valid && in_ready;
        len  = (state_q == LOAD_CUR) ? ROW_AW'(MACRO_DIM) : ROW_AW'(SEARCH_DIM);
    end
    me_row_packer #(
        .MAX_LEN (SEARCH_DIM),
        .PIXEL_W (PIXEL_W),
        .CNT_W   (ROW_AW)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .push_i     (xfer),
        .pixel_i    (in_pixel),
        .len_i      (len),
        .row_o      (row_word),
        .row_done_o (row_done)
    );
    // row counter advance and one-cycle-late RAM writes; address and data hold between writes
    always_comb begin
        last_row    = row_q == len - 1'b1;
        region_done = row_done && last_row;
        row_d       = row_done ? (last_row ? '0 : row_q + 1'b1) : row_q;
        cur_we_d    = row_done && (state_q == LOAD_CUR);
        sw_we_d     = row_done && (state_q == LOAD_SW);
        cur_waddr_d = cur_we_d ? row_q : cur_waddr_q;
        cur_wdata_d = cur_we_d ? row_word[CW-1:0] : cur_wdata_q;
        sw_waddr_d  = sw_we_d ? row_q : sw_waddr_q;
        sw_wdata_d  = sw_we_d ? row_word : sw_wdata_q;
    end
    // loader state transitions
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = en ? LOAD_CUR : IDLE;
            LOAD_CUR:  state_d = region_done ? LOAD_SW : LOAD_CUR;
            LOAD_SW:   state_d = region_done ? KICK : LOAD_SW;
            KICK:      state_d = me_ready ? WAIT_BUSY : KICK;
            WAIT_BUSY: state_d = me_ready ? WAIT_BUSY : WAIT_DONE;
            WAIT_DONE: state_d = me_ready ? IDLE : WAIT_DONE;
            default:   state_d = IDLE;
        endcase
    end
    // state-decoded outputs; start and done are tied to me_ready so start never fires while it is low
    always_comb begin
        in_ready   = (state_q == LOAD_CUR) || (state_q == LOAD_SW);
        busy       = state_q != IDLE;
        me_start   = (state_q == KICK) && me_ready;
        block_done = (state_q == WAIT_DONE) && me_ready;
    end
    // state, row counter and write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            cur_we_q    <= 1'b0;
            cur_waddr_q <= '0;
            cur_wdata_q <= '0;
            sw_we_q     <= 1'b0;
            sw_waddr_q  <= '0;
            sw_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cur_we_q    <= cur_we_d;
            cur_waddr_q <= cur_waddr_d;
            cur_wdata_q <= cur_wdata_d;
            sw_we_q     <= sw_we_d;
            sw_waddr_q  <= sw_waddr_d;
            sw_wdata_q  <= sw_wdata_d;
        end
    end
    assign cur_we    = cur_we_q;
    assign cur_waddr = cur_waddr_q;
    assign cur_wdata = cur_wdata_q;
    assign sw_we     = sw_we_q;
    assign sw_waddr  = sw_waddr_q;
    assign sw_wdata  = sw_wdata_q;
`ifdef ME_LOAD_CHECK_EN
    logic err_q, err_d;
    // in_last must accompany exactly the last pixel of the last search row
    always_comb err_d = err_q || (xfer && (in_last != (region_done && (state_q == LOAD_SW))));
    // sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err = err_q;
`endif
endmodule
